// File: rtl/multdiv_iter_ctrl.sv
// Iteration controller for the multi-cycle multiply/divide datapath.
// Sequences CYCLES step cycles per start, then issues a one-cycle done pulse.
module multdiv_iter_ctrl #(
    parameter int unsigned CYCLES = 32,
    parameter int unsigned WIDTH  = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             step,
    output logic             first,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic             inc;
    logic             load_zero;
    logic [WIDTH-1:0] tgl;

    assign last = (count == LAST);
    assign inc  = (state == RUN) && !last;

    // Counter is only nonzero in RUN (counting) and DONE (holding LAST);
    // every exit from RUN/DONE, and every entry into RUN, sees a zero load.
    assign load_zero = (state != RUN) || abort;

    always_comb begin
        tgl    = '0;
        tgl[0] = inc;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            tgl[i] = tgl[i-1] & count[i-1];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) state_nxt = RUN;
            end
            RUN: begin
                if (abort)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE: begin
                if (start && !abort) state_nxt = RUN;
                else                 state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (load_zero) count <= '0;
            else           count <= count ^ tgl;
        end
    end

    assign busy  = (state == RUN);
    assign step  = (state == RUN);
    assign first = (state == RUN) && (count == '0);
    assign done  = (state == DONE);

endmodule
